adder_sequencer: RTL

//   Adds two W-bit operands (W = N*CHUNKS) plus carry-in using one N-bit

---
 rtl/adder_sequencer_if.sv | 25 ++
 rtl/adder_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/adder_sequencer_if.sv
// Ready/valid operand and result bundle for adder_sequencer.
// The master side is the producer/consumer pair; the slave side is the sequencer.
interface adder_sequencer_if #(
    parameter int unsigned W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/adder_sequencer.sv
// Wide adder built from one N-bit adder_n reused over CHUNKS clocks, LSB chunk first,
// with the ripple carry held in a register between chunks.
module adder_n #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c,
    output logic [N-1:0] o_sum,
    output logic         o_c
);
    assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c};
endmodule

module adder_sequencer #(
    parameter int unsigned N      = 4,
    parameter int unsigned CHUNKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    adder_sequencer_if.slave bus
);
    localparam int unsigned   W         = N * CHUNKS;
    localparam int unsigned   CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LastChunk = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic          r_carry;
    logic          w_carry_d;
    logic          r_c_out;
    logic          w_c_out_d;
    logic [W-1:0]  r_a;
    logic [W-1:0]  w_a_d;
    logic [W-1:0]  r_b;
    logic [W-1:0]  w_b_d;
    logic [W-1:0]  r_sum;
    logic [W-1:0]  w_sum_d;

    logic [31:0]   w_shift;
    logic [N-1:0]  w_a_chunk;
    logic [N-1:0]  w_b_chunk;
    logic [N-1:0]  w_add_sum;
    logic          w_add_c;
    logic [W-1:0]  w_chunk_mask;
    logic [W-1:0]  w_chunk_sum;

    // Chunk k occupies bits [k*N +: N] of the operands and the sum.
    assign w_shift      = N * 32'(r_cnt);
    assign w_a_chunk    = N'(r_a >> w_shift);
    assign w_b_chunk    = N'(r_b >> w_shift);
    assign w_chunk_mask = W'({N{1'b1}}) << w_shift;
    assign w_chunk_sum  = W'(w_add_sum) << w_shift;

    adder_n #(
        .N(N)
    ) u_adder (
        .i_a  (w_a_chunk),
        .i_b  (w_b_chunk),
        .i_c  (r_carry),
        .o_sum(w_add_sum),
        .o_c  (w_add_c)
    );

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_carry_d = r_carry;
        w_c_out_d = r_c_out;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_sum_d   = r_sum;
        case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_a_d     = bus.a;
                    w_b_d     = bus.b;
                    w_carry_d = bus.c_in;
                    w_sum_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                w_sum_d   = (r_sum & ~w_chunk_mask) | w_chunk_sum;
                w_carry_d = w_add_c;
                if (r_cnt == LastChunk) begin
                    w_c_out_d = w_add_c;
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_carry <= w_carry_d;
            r_c_out <= w_c_out_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_sum   <= w_sum_d;
        end
    end

    // Handshake outputs decode state only, so nothing combinational reaches in_ready.
    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
endmodule
